// File: rtl/f_down_counter_pkg.sv
// Shared constants for the down-counter family: default width and FSM state encoding.
package f_down_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] RUN    = 2'b01;
    localparam logic [1:0] RELOAD = 2'b10;

endpackage

// File: rtl/f_down_counter.sv
// Loadable down counter with registered terminal-count pulse and optional auto-reload.
module f_down_counter
    import f_down_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] counter_out,
    output logic             busy,
    output logic             done
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        // Load wins over everything, so a terminal count in the same cycle never pulses done.
        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            if (load_value != '0) begin
                state_d = RUN;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (enable) begin
                        if (count_q > WIDTH'(1)) begin
                            count_d = count_q - WIDTH'(1);
                        end else begin
                            count_d = '0;
                            done_d  = 1'b1;
                            state_d = auto_reload ? RELOAD : IDLE;
                        end
                    end
                end
                RELOAD: begin
                    count_d = reload_q;
                    state_d = RUN;
                end
                IDLE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    assign counter_out = count_q;
    assign done        = done_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_f_down_counter.sv
// Directed and randomized check of f_down_counter against a rule-level reference model.
module tb_f_down_counter;

    localparam int unsigned WIDTH = 4;

    logic             clock;
    logic             reset;
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             auto_reload;
    logic [WIDTH-1:0] counter_out;
    logic             busy;
    logic             done;

    int checks;
    int errors;

    // Reference model: remaining count, saved start value, and two activity flags.
    int m_count;
    int m_saved;
    bit m_counting;
    bit m_refill;
    bit m_done;

    f_down_counter #(
        .WIDTH(WIDTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .load_value (load_value),
        .auto_reload(auto_reload),
        .counter_out(counter_out),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!reset) begin
            m_count    = 0;
            m_saved    = 0;
            m_counting = 0;
            m_refill   = 0;
            m_done     = 0;
        end else if (load) begin
            m_count    = int'(load_value);
            m_saved    = int'(load_value);
            m_counting = (load_value != 0);
            m_refill   = 0;
            m_done     = (load_value == 0);
        end else if (m_refill) begin
            m_count    = m_saved;
            m_refill   = 0;
            m_counting = 1;
            m_done     = 0;
        end else if (m_counting && enable) begin
            if (m_count >= 2) begin
                m_count = m_count - 1;
                m_done  = 0;
            end else begin
                m_count    = 0;
                m_done     = 1;
                m_counting = 0;
                m_refill   = auto_reload;
            end
        end else begin
            m_done = 0;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check("count", int'(counter_out), m_count);
        check("busy", int'(busy), int'(m_counting || m_refill));
        check("done", int'(done), int'(m_done));
    endtask

    task automatic tick_expect(input string tag, input int exp_count);
        tick();
        check(tag, int'(counter_out), exp_count);
    endtask

    initial begin
        int seq_basic [6] = '{5, 4, 3, 2, 1, 0};
        int seq_pause [8] = '{4, 3, 2, 2, 2, 2, 1, 0};
        int seq_auto  [8] = '{3, 2, 1, 0, 3, 2, 1, 0};
        int done_seen;
        int n;

        checks = 0;
        errors = 0;
        m_count = 0; m_saved = 0; m_counting = 0; m_refill = 0; m_done = 0;
        reset = 1'b0; enable = 1'b1; load = 1'b1; load_value = 4'd7; auto_reload = 1'b0;

        // Reset overrides a simultaneous load.
        tick();
        tick();
        check("reset_busy", int'(busy), 0);
        load = 1'b0;
        reset = 1'b1;
        tick();

        // Basic count with done on the edge reaching 0.
        load = 1'b1; load_value = 4'd5; enable = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick_expect("basic_seq", seq_basic[i]);
            load = 1'b0;
            done_seen += int'(done);
        end
        check("basic_done_cnt", done_seen, 1);
        check("basic_done_end", int'(done), 1);
        check("basic_busy_end", int'(busy), 0);
        tick();

        // Pause holds the count.
        load = 1'b1; load_value = 4'd4; enable = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick_expect("pause_seq", seq_pause[i]);
            load = 1'b0;
            enable = !(i >= 2 && i <= 4);
            done_seen += int'(done);
        end
        check("pause_done_cnt", done_seen, 1);
        enable = 1'b1;

        // Auto-reload restarts from the captured value; busy never drops.
        auto_reload = 1'b1; load = 1'b1; load_value = 4'd3;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick_expect("auto_seq", seq_auto[i]);
            load = 1'b0;
            check("auto_busy", int'(busy), 1);
            done_seen += int'(done);
        end
        check("auto_done_cnt", done_seen, 2);
        auto_reload = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("auto_off_idle", int'(busy), 0);

        // Load at terminal count preempts done.
        load = 1'b1; load_value = 4'd2;
        tick_expect("term_load2", 2);
        load = 1'b0;
        tick_expect("term_at1", 1);
        load = 1'b1; load_value = 4'd9;
        tick_expect("term_load9", 9);
        check("term_no_done", int'(done), 0);
        load = 1'b0;

        // Reset mid-run abandons the count.
        tick_expect("mid_8", 8);
        tick_expect("mid_7", 7);
        tick_expect("mid_6", 6);
        reset = 1'b0;
        tick_expect("mid_rst", 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick_expect("mid_quiet", 0);

        // Zero load pulses done and stays idle, even with auto-reload.
        auto_reload = 1'b1; load = 1'b1; load_value = 4'd0;
        tick();
        check("zero_done", int'(done), 1);
        check("zero_busy", int'(busy), 0);
        load = 1'b0;
        tick();
        check("zero_done_off", int'(done), 0);
        auto_reload = 1'b0;

        // All-ones load reaches done after exactly 15 enabled edges.
        load = 1'b1; load_value = '1;
        tick();
        load = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            n++;
        end
        check("ones_latency", n, 15);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(0, 40) != 0);
            load        = ($urandom_range(0, 9) == 0);
            load_value  = WIDTH'($urandom_range(0, 15));
            enable      = ($urandom_range(0, 3) != 0);
            auto_reload = $urandom_range(0, 1) == 1;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
